// File: rtl/mac_operand_sequencer.sv
// Operand-side sequencer for C = A*B: walks (i, j, k), issues A/B reads and registers each product.
// Define MAC_SEQ_SIGNED_EN for a two's-complement multiply; the default build multiplies unsigned.
module mac_operand_sequencer #(
  parameter int M                      = 4,
  parameter int K                      = 4,
  parameter int N                      = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32,
  localparam int MW = (M > 1) ? $clog2(M) : 1,
  localparam int KW = (K > 1) ? $clog2(K) : 1,
  localparam int NW = (N > 1) ? $clog2(N) : 1,
  localparam int W  = DATA_WIDTH_INIT_MATRIX
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [MW-1:0]   row_addr_a,
  output logic [KW-1:0]   col_addr_a,
  output logic [KW-1:0]   row_addr_b,
  output logic [NW-1:0]   col_addr_b,
  input  logic [W-1:0]    data_in_a,
  input  logic [W-1:0]    data_in_b,
  output logic [2*W-1:0]  product_reg,
  output logic [MW-1:0]   matrix_a_row_addr_counter_reg,
  output logic [KW-1:0]   matrix_a_col_addr_counter_reg,
  output logic [KW-1:0]   matrix_b_row_addr_counter_reg,
  output logic [NW-1:0]   matrix_b_col_addr_counter_reg,
  output logic            mult_done_reg,
  output logic [1:0]      state_dbg
);

  // Handshake: start is a level sampled only in IDLE; mult_done_reg qualifies
  // product_reg and its counters for exactly that cycle, with no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [MW-1:0] M_LAST = MW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  state_t          state_q, state_d;
  logic            drain_cnt_q, drain_cnt_d;
  logic [MW-1:0]   i_q, i_d;
  logic [NW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic            s1_valid_q, s1_valid_d;
  logic [MW-1:0]   s1_i_q, s1_i_d;
  logic [NW-1:0]   s1_j_q, s1_j_d;
  logic [KW-1:0]   s1_k_q, s1_k_d;
  logic [2*W-1:0]  product_q, product_d;
  logic [MW-1:0]   p_i_q, p_i_d;
  logic [NW-1:0]   p_j_q, p_j_d;
  logic [KW-1:0]   p_k_q, p_k_d;
  logic            mult_done_q, mult_done_d;
  logic            issue;
  logic [2*W-1:0]  a_ext, b_ext, mul_full;

  always_comb begin
`ifdef MAC_SEQ_SIGNED_EN
    a_ext = {{W{data_in_a[W-1]}}, data_in_a};
    b_ext = {{W{data_in_b[W-1]}}, data_in_b};
`else
    a_ext = {{W{1'b0}}, data_in_a};
    b_ext = {{W{1'b0}}, data_in_b};
`endif
    // Low 2W bits of the extended product are exact for both signednesses.
    mul_full = a_ext * b_ext;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    issue       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        // The final issue leaves the address registers parked on (M-1, N-1, K-1).
        if (i_q == M_LAST && j_q == N_LAST && k_q == K_LAST) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 1'b0;
        end else if (k_q != K_LAST) begin
          k_d = k_q + 1'b1;
        end else begin
          k_d = '0;
          if (j_q != N_LAST) begin
            j_d = j_q + 1'b1;
          end else begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q) state_d = S_DONE;
        else             drain_cnt_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    s1_valid_d  = issue;
    s1_i_d      = i_q;
    s1_j_d      = j_q;
    s1_k_d      = k_q;

    mult_done_d = s1_valid_q;
    product_d   = product_q;
    p_i_d       = p_i_q;
    p_j_d       = p_j_q;
    p_k_d       = p_k_q;
    if (s1_valid_q) begin
      product_d = mul_full;
      p_i_d     = s1_i_q;
      p_j_d     = s1_j_q;
      p_k_d     = s1_k_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_i_q      <= '0;
      s1_j_q      <= '0;
      s1_k_q      <= '0;
      product_q   <= '0;
      p_i_q       <= '0;
      p_j_q       <= '0;
      p_k_q       <= '0;
      mult_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      s1_valid_q  <= s1_valid_d;
      s1_i_q      <= s1_i_d;
      s1_j_q      <= s1_j_d;
      s1_k_q      <= s1_k_d;
      product_q   <= product_d;
      p_i_q       <= p_i_d;
      p_j_q       <= p_j_d;
      p_k_q       <= p_k_d;
      mult_done_q <= mult_done_d;
    end
  end

  assign busy                          = (state_q != S_IDLE);
  assign done                          = (state_q == S_DONE);
  assign row_addr_a                    = i_q;
  assign col_addr_a                    = k_q;
  assign row_addr_b                    = k_q;
  assign col_addr_b                    = j_q;
  assign product_reg                   = product_q;
  assign matrix_a_row_addr_counter_reg = p_i_q;
  assign matrix_a_col_addr_counter_reg = p_k_q;
  assign matrix_b_row_addr_counter_reg = p_k_q;
  assign matrix_b_col_addr_counter_reg = p_j_q;
  assign mult_done_reg                 = mult_done_q;
  assign state_dbg                     = state_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer (4x4x4, 32-bit operands).
// A 1-cycle-latency memory model feeds operands; a scoreboard checks every product beat.
module tb_mac_operand_sequencer;

  localparam int EW = 70;  // {i[1:0], j[1:0], k[1:0], product[63:0]}

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mult_done_reg;
  logic [1:0]  row_addr_a, col_addr_a, row_addr_b, col_addr_b;
  logic [31:0] data_in_a = '0, data_in_b = '0;
  logic [63:0] product_reg;
  logic [1:0]  a_row_c, a_col_c, b_row_c, b_col_c;
  logic [1:0]  state_dbg;

  mac_operand_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
    .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .product_reg(product_reg),
    .matrix_a_row_addr_counter_reg(a_row_c), .matrix_a_col_addr_counter_reg(a_col_c),
    .matrix_b_row_addr_counter_reg(b_row_c), .matrix_b_col_addr_counter_reg(b_col_c),
    .mult_done_reg(mult_done_reg), .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- memory model ----------------
  logic [31:0] mem_a [4][4];
  logic [31:0] mem_b [4][4];
  bit          force_mode = 1'b0;
  logic [31:0] fa = '0, fb = '0;

  initial begin
    logic [1:0] ra, ca, rb, cb;
    forever begin
      @(negedge clk);
      ra = row_addr_a; ca = col_addr_a; rb = row_addr_b; cb = col_addr_b;
      @(posedge clk);
      #1;
      if (force_mode) begin
        data_in_a = fa;
        data_in_b = fb;
      end else begin
        data_in_a = mem_a[ra][ca];
        data_in_b = mem_b[rb][cb];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MAC_SEQ_SIGNED_EN
    return 64'($signed(a)) * 64'($signed(b));
`else
    return 64'(a) * 64'(b);
`endif
  endfunction

  // One pass in (i, j, k) order, k fastest.
  task automatic push_pass();
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) begin
          a = force_mode ? fa : mem_a[i][k];
          b = force_mode ? fb : mem_b[k][j];
          exp_q.push_back({2'(i), 2'(j), 2'(k), model_mul(a, b)});
        end
  endtask

  int beats, first_t, last_t, done_t, done_cnt;
  logic [63:0] prod_212, last_prod;

  initial forever begin
    logic [EW-1:0] e;
    int t;
    @(negedge clk);
    t = cyc + 1;
    if (mult_done_reg) begin
      beats++;
      if (first_t < 0) first_t = t;
      last_t    = t;
      last_prod = product_reg;
      if (a_row_c == 2'd2 && b_col_c == 2'd1 && a_col_c == 2'd2) prod_212 = product_reg;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got mult_done_reg=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("beat_product", product_reg, e[63:0]);
        check("beat_i", 64'(a_row_c), 64'(e[69:68]));
        check("beat_j", 64'(b_col_c), 64'(e[67:66]));
        check("beat_k_a", 64'(a_col_c), 64'(e[65:64]));
        check("beat_k_b", 64'(b_row_c), 64'(e[65:64]));
      end
    end
    if (done) begin
      done_cnt++;
      done_t = t;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    beats = 0; first_t = -1; last_t = -1; done_t = -1; done_cnt = 0;
    prod_212 = '0; last_prod = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_addr"}, 64'({row_addr_a, col_addr_a, row_addr_b, col_addr_b}), 64'd0);
    check({tag, "_product"}, product_reg, 64'd0);
    check({tag, "_counters"}, 64'({a_row_c, a_col_c, b_row_c, b_col_c}), 64'd0);
    check({tag, "_mult_done"}, 64'(mult_done_reg), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  // Pulses start for one cycle; returns E0, the edge that sampled it.
  task automatic pulse_start(output int e0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic run_full_pass(input bit extra_pulses);
    int e0, t;
    clear_stats();
    push_pass();
    pulse_start(e0);
    for (int n = 0; n < 80; n++) begin
      t = e0 + n + 1;
      if (n < 64) begin
        check("issue_row_a", 64'(row_addr_a), 64'(n / 16));
        check("issue_col_b", 64'(col_addr_b), 64'((n / 4) % 4));
        check("issue_col_a", 64'(col_addr_a), 64'(n % 4));
        check("issue_row_b", 64'(row_addr_b), 64'(n % 4));
      end
      check("busy", 64'(busy), 64'((t >= e0 + 1 && t <= e0 + 67) ? 1 : 0));
      start = (extra_pulses && (n == 9 || n == 66)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("pass_beats", 64'(beats), 64'd64);
    check("first_beat_cycle", 64'(first_t - e0), 64'd3);
    check("last_beat_cycle", 64'(last_t - e0), 64'd66);
    check("done_cycle", 64'(done_t - e0), 64'd67);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e0;
    clear_stats();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem_a[r][c] = (r == c) ? 32'd1 : 32'd0;
        mem_b[r][c] = 32'(4 * r + c);
      end

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Identity x ramp, with ignored start pulses at issue 10 and in DONE.
    run_full_pass(1'b1);
    check("ident_prod_212", prod_212, 64'd9);

    force_mode = 1'b1;
    fa = 32'hFFFF_FFFF; fb = 32'hFFFF_FFFF;
    run_full_pass(1'b0);
`ifdef MAC_SEQ_SIGNED_EN
    check("max_operands", last_prod, 64'd1);
`else
    check("max_operands", last_prod, 64'hFFFF_FFFE_0000_0001);
`endif

    fa = 32'hFFFF_FFFD; fb = 32'd5;
    run_full_pass(1'b0);
`ifdef MAC_SEQ_SIGNED_EN
    check("neg3_times_5", last_prod, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    check("neg3_times_5", last_prod, 64'h0000_0004_FFFF_FFF1);
`endif
    force_mode = 1'b0;

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem_a[r][c] = 32'(r * 4 + c + 3);
        mem_b[r][c] = 32'(r * 7 + c + 100);
      end

    // Reset during issue 20: 18 beats land before it, none after.
    clear_stats();
    push_pass();
    pulse_start(e0);
    repeat (19) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check_all_zero("midreset");
    check("beats_before_reset", 64'(beats), 64'd18);
    resetn = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("post_reset_idle", 64'({busy, mult_done_reg, done}), 64'd0);
    end
    check("no_beats_after_reset", 64'(beats), 64'd18);

    run_full_pass(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mac_operand_sequencer.md
# mac_operand_sequencer

Operand-side initiator for the matrix-multiply MAC path. On `start` it walks every (row i, column j, inner k) index of C = A·B and issues read addresses to the A and B operand memories. It multiplies each returned operand pair and presents `product_reg` to the accumulator unit, together with the index counters aligned to that product and a `mult_done_reg` qualifier. The accumulator then forms and writes each C element.

## Interface
Parameters:
- `M`, default 4: rows of A and C.
- `K`, default 4: columns of A, rows of B (inner dimension).
- `N`, default 4: columns of B and C.
- `DATA_WIDTH_INIT_MATRIX`, default 32: operand width for A and B.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `resetn`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin one full C = A·B pass; honoured only in IDLE.
- `busy`, out, 1: pass in progress.
- `done`, out, 1: one-cycle pulse at end of pass.
- `row_addr_a`, out, $clog2(M): A read row (i).
- `col_addr_a`, out, $clog2(K): A read column (k).
- `row_addr_b`, out, $clog2(K): B read row (k).
- `col_addr_b`, out, $clog2(N): B read column (j).
- `data_in_a`, in, DATA_WIDTH_INIT_MATRIX: A read data, one cycle after address.
- `data_in_b`, in, DATA_WIDTH_INIT_MATRIX: B read data, one cycle after address.
- `product_reg`, out, 2*DATA_WIDTH_INIT_MATRIX: registered A×B product.
- `matrix_a_row_addr_counter_reg`, out, $clog2(M): i aligned to `product_reg`.
- `matrix_a_col_addr_counter_reg`, out, $clog2(K): k aligned to `product_reg`.
- `matrix_b_row_addr_counter_reg`, out, $clog2(K): k aligned to `product_reg` (equals A column).
- `matrix_b_col_addr_counter_reg`, out, $clog2(N): j aligned to `product_reg`.
- `mult_done_reg`, out, 1: `product_reg` and the aligned counters are valid this cycle.

## Operation
- FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: `busy`=0. If `start`=1 is sampled, load i=j=k=0 and go to RUN.
  - RUN: one issue per cycle. Index order is k innermost, then j, then i. k wraps K-1->0 and increments j; j wraps N-1->0 and increments i. On the issue (M-1, N-1, K-1), go to DRAIN.
  - DRAIN: two cycles, flushing the read and multiply stages. Then go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Pipeline:
  - Stage 0: address registers drive the memories.
  - Stage 1: index and valid are delayed one cycle to match the memory latency.
  - Stage 2: `product_reg` <= `data_in_a` * `data_in_b`. Aligned counters and `mult_done_reg` are registered on the same edge.
- Arithmetic: full-precision 2W-bit product, no truncation or saturation. Unsigned unless the configuration macro below is defined.
- `start` outside IDLE is ignored, including in the DONE cycle. There is no abort input.
- Reset asserted mid-pass: state returns to IDLE on the next edge. All outputs go to zero and in-flight products are discarded; `mult_done_reg` is never asserted after the reset edge.
- Exactly M*N*K `mult_done_reg` beats per pass, and no gaps between them.
- Every K-th beat carries k=K-1, which marks the accumulator's write beat.

## Timing
- Reset values: every output is 0, including addresses, `product_reg`, counters, `busy`, `done` and `mult_done_reg`.
- Let `start` be sampled at edge E0. First issue cycle is E0+1; `busy`=1 from E0+1 through the DONE cycle inclusive.
- Issue at cycle c gives read data at c+1 and `mult_done_reg`=1 at c+2 with the matching indices.
- Last issue at E0+M*N*K. Last `mult_done_reg` at E0+M*N*K+2. `done` pulse at E0+M*N*K+3.
- Defaults (64 issues): `done` at E0+67. Next `start` is accepted from E0+68.
- Address outputs hold their last value in DRAIN, DONE and IDLE. `mult_done_reg`=0 whenever no valid product is present.

## Configuration
- `MAC_SEQ_SIGNED_EN` defined: operands are two's-complement and the multiply is signed (`$signed`). `product_reg` is the signed 2W-bit result.
- `MAC_SEQ_SIGNED_EN` undefined: the multiply is unsigned.
- Ports, latency and FSM are identical in both builds.

## Test plan
- Reset, then pulse `start` with defaults:
  - addresses step (0,0,0),(0,0,1),...,(3,3,3);
  - 64 contiguous `mult_done_reg` beats;
  - `done` at E0+67; `busy` falls at E0+68.
- A=identity, B[k][j]=4k+j: products nonzero only where k=i. The beat at (i=2, j=1, k=2) gives `product_reg`=9.
- Unsigned build, data_in_a=data_in_b=32'hFFFF_FFFF: `product_reg`=64'hFFFF_FFFE_0000_0001.
- Signed build, same data (-1×-1): `product_reg`=1. For -3×5: `product_reg`=-15 (64'hFFFF_FFFF_FFFF_FFF1).
- Pulse `start` again at issue 10 and in the DONE cycle: both ignored, and the pass count stays exactly 64 beats.
- Drop `resetn` low for one cycle at issue 20: all outputs 0 on the next edge, no further `mult_done_reg`, FSM in IDLE. A new `start` then restarts from (0,0,0).
